// File: rtl/ifetch_pkg.sv
// ifetch_pkg -- shared types and constants for the instruction-fetch controller (rev 1.0)
`default_nettype none

package ifetch_pkg;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    HALT  = 1'b1
  } state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] INST_NOP         = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fifo_entry_t;

endpackage

`default_nettype wire

// File: rtl/ifetch_fifo.sv
// ifetch_fifo -- prefetch FIFO of {inst, pc} entries with flush (rev 1.0)
`default_nettype none

module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic        pop,
  input  logic        flush,
  input  fifo_entry_t din,
  output fifo_entry_t head,
  output logic        full,
  output logic        empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fifo_entry_t      mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Empty head reads zero so downstream never sees stale storage.
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl -- fetch PC sequencer driving the instruction ROM and a prefetch FIFO (rev 1.0)
`default_nettype none

module ifetch_ctrl
  import ifetch_pkg::*;
#(
  parameter int          ADDR_W     = 10,
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst,
  output logic [31:0]       inst_pc,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  input  logic              halt_req,
  input  logic [31:0]       halt_pc,
  input  logic              resume,
  output logic              halted,
  output logic              misalign_err
);

  state_t      state;
  state_t      state_nx;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_pc_nx;
  logic        misalign_nx;
  logic        push;
  logic        pop;
  logic        flush;
  logic        full;
  logic        empty;
  fifo_entry_t head;
  fifo_entry_t din;

  assign rom_addr   = fetch_pc[ADDR_W+1:2];
  assign inst_valid = !empty && (state == FETCH);
  assign inst       = head.inst;
  assign inst_pc    = head.pc;
  assign halted     = (state == HALT);
  assign din        = '{inst: rom_data, pc: fetch_pc};

  // Priority: halt_req over redirect over normal push/pop; flush discards both.
  always_comb begin
    state_nx    = state;
    fetch_pc_nx = fetch_pc;
    misalign_nx = misalign_err;
    push        = 1'b0;
    pop         = 1'b0;
    flush       = 1'b0;
    case (state)
      FETCH: begin
        if (halt_req) begin
          flush       = 1'b1;
          fetch_pc_nx = halt_pc + PC_STEP;
          state_nx    = HALT;
        end else if (redirect_valid) begin
          flush = 1'b1;
          if (redirect_pc[1:0] != 2'b00) begin
            misalign_nx = 1'b1;
            state_nx    = HALT;
          end else begin
            fetch_pc_nx = redirect_pc;
          end
        end else begin
          pop  = inst_valid && inst_ready;
          push = !full || pop;
          if (push) fetch_pc_nx = fetch_pc + PC_STEP;
        end
      end
      default: begin
        if (resume && !misalign_err) state_nx = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= FETCH;
      fetch_pc     <= RESET_PC;
      misalign_err <= 1'b0;
    end else begin
      state        <= state_nx;
      fetch_pc     <= fetch_pc_nx;
      misalign_err <= misalign_nx;
    end
  end

  ifetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (din),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

endmodule

`default_nettype wire

// File: tb/tb_ifetch_ctrl.sv
// tb_ifetch_ctrl -- table vectors plus scoreboard for the fetch controller (rev 1.0)
`default_nettype none

module tb_ifetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic [9:0]  rom_addr;
  logic [31:0] rom_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic [31:0] halt_pc;
  logic        resume;
  logic        halted;
  logic        misalign_err;

  logic [31:0] rom_mem [0:1023];
  assign rom_data = rom_mem[rom_addr];

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } exp_t;

  typedef struct {
    logic        ready;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_inst;
    logic [9:0]  exp_addr;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[10];
  int   checks = 0;
  int   errors = 0;

  ifetch_ctrl #(
    .ADDR_W     (10),
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
    .halt_pc        (halt_pc),
    .resume         (resume),
    .halted         (halted),
    .misalign_err   (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc);
    exp_t e;
    e.inst = rom_mem[pc[11:2]];
    e.pc   = pc;
    sb.push_back(e);
  endtask

  // Evaluates the handshake that the coming edge will honour, then steps one cycle.
  task automatic tick();
    #2;
    if (inst_valid && inst_ready && !redirect_valid && !halt_req && sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("sb_pc", inst_pc, e.pc);
      chk("sb_inst", inst, e.inst);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name, input int exp_ticks);
    int n;
    n = 0;
    while (sb.size() > 0 && n < 20) begin
      tick();
      n++;
    end
    chk({name, "_ticks"}, n, exp_ticks);
    chk({name, "_left"}, sb.size(), 0);
    sb.delete();
    inst_ready = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom_mem[i] = 32'h0;
    rom_mem[0]     = 32'h0010_0493;
    rom_mem[1]     = 32'h0100_006f;
    rom_mem[2]     = 32'h0010_0493;
    rom_mem[17]    = 32'h29c0_00ef;
    rom_mem[18]    = 32'h0010_0413;
    rom_mem[19]    = 32'h00a0_0893;
    rom_mem[184]   = 32'h0000_0073;
    rom_mem[1023]  = 32'h0000_006f;

    // ready, valid, pc, inst, rom_addr -- starting in the first cycle after reset release
    vecs[0] = '{1'b0, 1'b0, 32'h0, 32'h0,         10'd0};
    vecs[1] = '{1'b0, 1'b1, 32'h0, 32'h0010_0493, 10'd1};
    vecs[2] = '{1'b0, 1'b1, 32'h0, 32'h0010_0493, 10'd2};
    vecs[3] = '{1'b0, 1'b1, 32'h0, 32'h0010_0493, 10'd2};
    vecs[4] = '{1'b0, 1'b1, 32'h0, 32'h0010_0493, 10'd2};
    vecs[5] = '{1'b0, 1'b1, 32'h0, 32'h0010_0493, 10'd2};
    vecs[6] = '{1'b1, 1'b1, 32'h0, 32'h0010_0493, 10'd2};
    vecs[7] = '{1'b1, 1'b1, 32'h4, 32'h0100_006f, 10'd3};
    vecs[8] = '{1'b1, 1'b1, 32'h8, 32'h0010_0493, 10'd4};
    vecs[9] = '{1'b0, 1'b1, 32'hC, 32'h0,         10'd5};

    rst_n = 1'b0;
    inst_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    halt_req = 1'b0;
    halt_pc = 32'h0;
    resume = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", inst_valid, 0);
    chk("rst_inst", inst, 0);
    chk("rst_pc", inst_pc, 0);
    chk("rst_halted", halted, 0);
    chk("rst_misalign", misalign_err, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      inst_ready = vecs[i].ready;
      #2;
      chk($sformatf("vec%0d_valid", i), inst_valid, vecs[i].exp_valid);
      chk($sformatf("vec%0d_pc", i), inst_pc, vecs[i].exp_pc);
      chk($sformatf("vec%0d_inst", i), inst, vecs[i].exp_inst);
      chk($sformatf("vec%0d_addr", i), rom_addr, vecs[i].exp_addr);
      @(posedge clk);
      #1;
    end

    // Aligned redirect: one bubble, then target stream.
    inst_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h44;
    tick();
    redirect_valid = 1'b0;
    push_exp(32'h44);
    push_exp(32'h48);
    push_exp(32'h4C);
    #2;
    chk("redir_bubble", inst_valid, 0);
    drain("redir", 4);

    // Redirect near the top of the address space wraps the PC.
    inst_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    push_exp(32'hFFFF_FFFC);
    push_exp(32'h0);
    #2;
    chk("wrap_addr", rom_addr, 10'h3FF);
    drain("wrap", 3);

    // Halt wins over a simultaneous redirect.
    inst_ready = 1'b1;
    halt_req = 1'b1;
    halt_pc = 32'h2D8;
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    tick();
    halt_req = 1'b0;
    redirect_valid = 1'b0;
    #2;
    chk("halt_halted", halted, 1);
    chk("halt_valid", inst_valid, 0);
    chk("halt_addr", rom_addr, 10'hB7);
    chk("halt_misalign", misalign_err, 0);
    tick();
    tick();
    chk("halt_hold_halted", halted, 1);
    chk("halt_hold_valid", inst_valid, 0);
    resume = 1'b1;
    tick();
    resume = 1'b0;
    push_exp(32'h2DC);
    push_exp(32'h2E0);
    #2;
    chk("resume_halted", halted, 0);
    chk("resume_valid", inst_valid, 0);
    drain("resume", 3);

    // Fill with decode stalled, then misaligned redirect.
    tick();
    tick();
    tick();
    #2;
    chk("full_valid", inst_valid, 1);
    chk("full_pc", inst_pc, 32'h2E4);
    chk("full_addr", rom_addr, 10'hBB);
    redirect_valid = 1'b1;
    redirect_pc = 32'h46;
    tick();
    redirect_valid = 1'b0;
    #2;
    chk("mis_err", misalign_err, 1);
    chk("mis_halted", halted, 1);
    chk("mis_valid", inst_valid, 0);
    chk("mis_addr", rom_addr, 10'hBB);
    resume = 1'b1;
    tick();
    resume = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h80;
    tick();
    redirect_valid = 1'b0;
    tick();
    chk("mis_stuck_halted", halted, 1);
    chk("mis_stuck_err", misalign_err, 1);
    chk("mis_stuck_valid", inst_valid, 0);
    chk("mis_stuck_addr", rom_addr, 10'hBB);

    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    chk("clr_err", misalign_err, 0);
    chk("clr_halted", halted, 0);

    // Asynchronous reset with the FIFO full, mid-cycle.
    tick();
    tick();
    tick();
    #2;
    chk("prefull_addr", rom_addr, 10'd2);
    chk("prefull_valid", inst_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", inst_valid, 0);
    chk("arst_inst", inst, 0);
    chk("arst_pc", inst_pc, 0);
    chk("arst_addr", rom_addr, 0);
    chk("arst_halted", halted, 0);
    chk("arst_misalign", misalign_err, 0);
    rst_n = 1'b1;
    inst_ready = 1'b1;
    push_exp(32'h0);
    push_exp(32'h4);
    push_exp(32'h8);
    drain("restart", 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
